// File: rtl/roic_pkg.sv
// Shared types and helpers for the ROIC pixel capture path.
package roic_pkg;

  localparam int unsigned N_ROWS = 16;
  localparam int unsigned N_COLS = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned LIN_W  = 2 * IDX_W;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    IN_FRAME   = 1'b1
  } cap_state_e;

  // Index and frame-position markers carried alongside every sample.
  typedef struct packed {
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic             sof;
    logic             eol;
    logic             eof;
  } pix_meta_t;

  // Priority-free decode: OR of the indices of all set bits.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_ROWS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < N_ROWS; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/roic_sync_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head.
module roic_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             valid_q, full_q;
  logic             push_c, pop_c;

  // A write is accepted on full only when the head leaves in the same cycle.
  always_comb begin
    pop_c     = rd_en_i && valid_q;
    push_c    = wr_en_i && (!full_q || pop_c);
    rd_ptr_d  = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d  = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    cnt_d     = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    rd_data_d = rd_data_q;
    if (push_c && (wr_ptr_q == rd_ptr_d)) begin
      rd_data_d = wr_data_i;
    end else if (pop_c) begin
      rd_data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
      valid_q   <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      valid_q   <= (cnt_d != '0);
      full_q    <= (cnt_d == CNT_W'(DEPTH));
    end
  end

  assign rd_data_o = rd_data_q;
  assign valid_o   = valid_q;
  assign full_o    = full_q;

endmodule

// File: rtl/roic_pixel_capture.sv
// Decodes scanner row/col strobes, captures ADC samples and streams them out.
// Optional pixel-order checking is enabled with ROIC_PIXEL_CAPTURE_ORDER_CHECK_EN.
module roic_pixel_capture
  import roic_pkg::*;
#(
  parameter int unsigned ADC_W      = 14,
  parameter int unsigned ADC_LAT    = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              master_rst,
  input  logic [N_ROWS-1:0] row,
  input  logic [N_COLS-1:0] col,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              err_clr,
  output logic [ADC_W-1:0]  pix_data,
  output logic [IDX_W-1:0]  pix_row,
  output logic [IDX_W-1:0]  pix_col,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              frame_done,
  output logic              enc_err,
  output logic              ovf_err,
  output logic              seq_err
);

  typedef struct packed {
    logic [ADC_W-1:0] data;
    pix_meta_t        meta;
  } pix_word_t;

  cap_state_e       state_q;
  logic             enc_err_q, ovf_err_q, frame_done_q;
  logic             row_hot_c, col_hot_c, strobe_c, enc_set_c, capture_c;
  logic [IDX_W-1:0] row_idx_c, col_idx_c;
  pix_meta_t        meta_c, due_meta_c;
  logic             due_vld_c, ovf_set_c, wr_ok_c;
  pix_word_t        wr_word_c, rd_word;
  logic             fifo_valid, fifo_full;

  // Strobe decode and capture decision for the current cycle.
  always_comb begin
    row_hot_c   = $onehot(row);
    col_hot_c   = $onehot(col);
    strobe_c    = row_hot_c && col_hot_c;
    enc_set_c   = ((row != '0) && !row_hot_c) || ((col != '0) && !col_hot_c);
    row_idx_c   = onehot_to_idx(row);
    col_idx_c   = onehot_to_idx(col);
    meta_c.row  = row_idx_c;
    meta_c.col  = col_idx_c;
    meta_c.sof  = (row_idx_c == '0) && (col_idx_c == '0);
    meta_c.eol  = (col_idx_c == IDX_W'(N_COLS - 1));
    meta_c.eof  = meta_c.eol && (row_idx_c == IDX_W'(N_ROWS - 1));
    capture_c   = strobe_c && ((state_q == IN_FRAME) || meta_c.sof);
  end

  // Delay the pixel descriptor until its ADC sample is valid.
  generate
    if (ADC_LAT == 0) begin : g_no_lat
      assign due_vld_c  = capture_c;
      assign due_meta_c = meta_c;
    end else begin : g_lat
      logic      vld_q  [ADC_LAT];
      pix_meta_t meta_q [ADC_LAT];

      always_ff @(posedge clk) begin
        if (master_rst) begin
          for (int unsigned i = 0; i < ADC_LAT; i++) begin
            vld_q[i]  <= 1'b0;
            meta_q[i] <= '0;
          end
        end else begin
          vld_q[0]  <= capture_c;
          meta_q[0] <= meta_c;
          for (int unsigned i = 1; i < ADC_LAT; i++) begin
            vld_q[i]  <= vld_q[i-1];
            meta_q[i] <= meta_q[i-1];
          end
        end
      end

      assign due_vld_c  = vld_q[ADC_LAT-1];
      assign due_meta_c = meta_q[ADC_LAT-1];
    end
  endgenerate

  always_comb begin
    wr_word_c.data = adc_data;
    wr_word_c.meta = due_meta_c;
    ovf_set_c      = due_vld_c && fifo_full && !(pix_ready && fifo_valid);
    wr_ok_c        = due_vld_c && !ovf_set_c;
  end

  roic_sync_fifo #(
    .WIDTH ($bits(pix_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_i     (master_rst),
    .wr_en_i   (due_vld_c),
    .wr_data_i (wr_word_c),
    .rd_en_i   (pix_ready),
    .rd_data_o (rd_word),
    .valid_o   (fifo_valid),
    .full_o    (fifo_full)
  );

  // Frame FSM, sticky errors and the frame-complete pulse.
  always_ff @(posedge clk) begin
    if (master_rst) begin
      state_q      <= WAIT_FRAME;
      enc_err_q    <= 1'b0;
      ovf_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (capture_c) state_q <= meta_c.eof ? WAIT_FRAME : IN_FRAME;
      enc_err_q    <= (enc_err_q && !err_clr) || enc_set_c;
      ovf_err_q    <= (ovf_err_q && !err_clr) || ovf_set_c;
      frame_done_q <= wr_ok_c && due_meta_c.eof;
    end
  end

`ifdef ROIC_PIXEL_CAPTURE_ORDER_CHECK_EN
  logic [LIN_W-1:0] exp_q, pix_lin_c;
  logic             seq_err_q, seq_set_c;

  // A (0,0) inside a frame mismatches naturally since exp_q never holds 0 there.
  always_comb begin
    pix_lin_c = {row_idx_c, col_idx_c};
    seq_set_c = strobe_c && (state_q == IN_FRAME) && (pix_lin_c != exp_q);
  end

  always_ff @(posedge clk) begin
    if (master_rst) begin
      exp_q     <= '0;
      seq_err_q <= 1'b0;
    end else begin
      seq_err_q <= (seq_err_q && !err_clr) || seq_set_c;
      if (capture_c) exp_q <= pix_lin_c + LIN_W'(1);
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

  assign pix_data   = rd_word.data;
  assign pix_row    = rd_word.meta.row;
  assign pix_col    = rd_word.meta.col;
  assign pix_sof    = rd_word.meta.sof;
  assign pix_eol    = rd_word.meta.eol;
  assign pix_eof    = rd_word.meta.eof;
  assign pix_valid  = fifo_valid;
  assign frame_done = frame_done_q;
  assign enc_err    = enc_err_q;
  assign ovf_err    = ovf_err_q;

endmodule

// File: tb/tb_roic_pixel_capture.sv
// Bench for roic_pixel_capture: two instances (ADC_LAT 1 and 3) against a queue-level model.
module tb_roic_pixel_capture;

  typedef struct packed {
    logic [13:0] d;
    logic [3:0]  r;
    logic [3:0]  c;
    logic        sof;
    logic        eol;
    logic        eof;
  } mpix_t;

  typedef struct packed {
    logic       v;
    logic [3:0] r;
    logic [3:0] c;
  } mcap_t;

`ifdef ROIC_PIXEL_CAPTURE_ORDER_CHECK_EN
  localparam bit ORDER = 1'b1;
`else
  localparam bit ORDER = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, err_clr, ready;
  logic [15:0] row, col;
  logic [13:0] adc    [2];
  logic [13:0] o_data [2];
  logic [3:0]  o_row  [2];
  logic [3:0]  o_col  [2];
  logic        o_sof  [2];
  logic        o_eol  [2];
  logic        o_eof  [2];
  logic        o_vld  [2];
  logic        o_fd   [2];
  logic        o_enc  [2];
  logic        o_ovf  [2];
  logic        o_seq  [2];

  roic_pixel_capture #(.ADC_W(14), .ADC_LAT(1), .FIFO_DEPTH(16)) u_dut0 (
    .clk(clk), .master_rst(rst), .row(row), .col(col), .adc_data(adc[0]), .err_clr(err_clr),
    .pix_data(o_data[0]), .pix_row(o_row[0]), .pix_col(o_col[0]), .pix_sof(o_sof[0]),
    .pix_eol(o_eol[0]), .pix_eof(o_eof[0]), .pix_valid(o_vld[0]), .pix_ready(ready),
    .frame_done(o_fd[0]), .enc_err(o_enc[0]), .ovf_err(o_ovf[0]), .seq_err(o_seq[0]));

  roic_pixel_capture #(.ADC_W(14), .ADC_LAT(3), .FIFO_DEPTH(16)) u_dut1 (
    .clk(clk), .master_rst(rst), .row(row), .col(col), .adc_data(adc[1]), .err_clr(err_clr),
    .pix_data(o_data[1]), .pix_row(o_row[1]), .pix_col(o_col[1]), .pix_sof(o_sof[1]),
    .pix_eol(o_eol[1]), .pix_eof(o_eof[1]), .pix_valid(o_vld[1]), .pix_ready(ready),
    .frame_done(o_fd[1]), .enc_err(o_enc[1]), .ovf_err(o_ovf[1]), .seq_err(o_seq[1]));

  int n_pass = 0;
  int n_total = 0;

  // Model state per instance
  mpix_t mf   [2][16];
  int    mcnt [2];
  mcap_t mh   [2][4];
  bit    m_in [2];
  int    mexp [2];
  bit    menc [2], movf [2], mseq [2], mfd [2];

  // DUT beat log
  mpix_t blog [2][300];
  int    bn   [2];
  int    fdn  [2];

  logic [15:0] rh [4];
  logic [15:0] ch [4];

  function automatic int idx(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [15:0] oh(input int n);
    logic [15:0] v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  function automatic logic [13:0] code(input logic [15:0] r, input logic [15:0] c);
    if ($countones(r) == 1 && $countones(c) == 1) return {6'h15, 4'(idx(r)), 4'(idx(c))};
    return 14'h0;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
  endtask

  task automatic model_edge();
    int    nr, nc, ri, ci;
    bit    strobe, encs, cap, seqs, pop, ovfs, wrote;
    mcap_t cur, due;
    mpix_t w;
    nr = $countones(row);
    nc = $countones(col);
    ri = idx(row);
    ci = idx(col);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_in[k] = 0; mexp[k] = 0; mcnt[k] = 0;
        menc[k] = 0; movf[k] = 0; mseq[k] = 0; mfd[k] = 0;
        for (int j = 0; j < 4; j++) mh[k][j] = '0;
      end else begin
        strobe = (nr == 1) && (nc == 1);
        encs   = (nr > 1) || (nc > 1);
        cap    = strobe && (m_in[k] || (ri == 0 && ci == 0));
        seqs   = ORDER && strobe && m_in[k] && (ri * 16 + ci != mexp[k]);
        if (cap) begin
          m_in[k] = !(ri == 15 && ci == 15);
          mexp[k] = ri * 16 + ci + 1;
        end
        cur.v = cap; cur.r = 4'(ri); cur.c = 4'(ci);
        due = (k == 0) ? mh[k][0] : mh[k][2];
        for (int j = 3; j > 0; j--) mh[k][j] = mh[k][j-1];
        mh[k][0] = cur;
        pop = (mcnt[k] > 0) && ready;
        if (pop) begin
          for (int j = 0; j < 15; j++) mf[k][j] = mf[k][j+1];
          mcnt[k]--;
        end
        wrote = 0;
        ovfs  = 0;
        if (due.v) begin
          if (mcnt[k] < 16) begin
            w.d = adc[k]; w.r = due.r; w.c = due.c;
            w.sof = (due.r == 0) && (due.c == 0);
            w.eol = (due.c == 15);
            w.eof = (due.r == 15) && (due.c == 15);
            mf[k][mcnt[k]] = w;
            mcnt[k]++;
            wrote = 1;
          end else begin
            ovfs = 1;
          end
        end
        mfd[k]  = wrote && due.r == 15 && due.c == 15;
        menc[k] = (menc[k] && !err_clr) || encs;
        movf[k] = (movf[k] && !err_clr) || ovfs;
        mseq[k] = (mseq[k] && !err_clr) || seqs;
      end
    end
  endtask

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      chk("valid", k, 32'(o_vld[k]), 32'(mcnt[k] > 0));
      if (mcnt[k] > 0)
        chk("beat", k, 32'({o_data[k], o_row[k], o_col[k], o_sof[k], o_eol[k], o_eof[k]}), 32'(mf[k][0]));
      chk("flags", k, 32'({o_enc[k], o_ovf[k], o_seq[k], o_fd[k]}), 32'({menc[k], movf[k], mseq[k], mfd[k]}));
      if (o_fd[k]) fdn[k]++;
    end
  endtask

  task automatic step(input logic [15:0] r, input logic [15:0] c);
    row = r;
    col = c;
    adc[0] = code(rh[0], ch[0]);
    adc[1] = code(rh[2], ch[2]);
    for (int k = 0; k < 2; k++) begin
      if (o_vld[k] && ready && bn[k] < 300) begin
        blog[k][bn[k]] = {o_data[k], o_row[k], o_col[k], o_sof[k], o_eol[k], o_eof[k]};
        bn[k]++;
      end
    end
    @(posedge clk);
    model_edge();
    for (int j = 3; j > 0; j--) begin
      rh[j] = rh[j-1];
      ch[j] = ch[j-1];
    end
    rh[0] = r;
    ch[0] = c;
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(16'h0, 16'h0);
  endtask

  task automatic clear_logs();
    for (int k = 0; k < 2; k++) begin
      bn[k]  = 0;
      fdn[k] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic run_frame(input int skip);
    for (int i = 0; i < 256; i++) if (i != skip) step(oh(i / 16), oh(i % 16));
  endtask

  initial begin
    rst = 1'b1; err_clr = 1'b0; ready = 1'b1;
    row = '0; col = '0; adc[0] = '0; adc[1] = '0;
    for (int j = 0; j < 4; j++) begin rh[j] = '0; ch[j] = '0; end
    clear_logs();
    idle(3);
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, 32'(o_vld[k]), 32'd0);
      chk("rst_flags", k, 32'({o_enc[k], o_ovf[k], o_seq[k], o_fd[k]}), 32'd0);
    end
    rst = 1'b0;

    // Full frame, always ready
    clear_logs();
    run_frame(-1);
    idle(8);
    for (int k = 0; k < 2; k++) begin
      chk("t1_beats", k, 32'(bn[k]), 32'd256);
      chk("t1_frame_done", k, 32'(fdn[k]), 32'd1);
      chk("t1_sof0", k, 32'(blog[k][0].sof), 32'd1);
      chk("t1_eol15", k, 32'(blog[k][15].eol), 32'd1);
      chk("t1_eol31", k, 32'(blog[k][31].eol), 32'd1);
      chk("t1_eol14", k, 32'(blog[k][14].eol), 32'd0);
      chk("t1_eof255", k, 32'(blog[k][255].eof), 32'd1);
      chk("t1_errs", k, 32'({o_enc[k], o_ovf[k], o_seq[k]}), 32'd0);
      for (int i = 0; i < 256; i++)
        chk("t1_pix", k, 32'({blog[k][i].d, blog[k][i].r, blog[k][i].c}), 32'({6'h15, 8'(i), 8'(i)}));
    end

    // Whole frame with downstream stalled
    clear_logs();
    ready = 1'b0;
    run_frame(-1);
    idle(4);
    for (int k = 0; k < 2; k++) begin
      chk("t2_ovf", k, 32'(o_ovf[k]), 32'd1);
      chk("t2_valid", k, 32'(o_vld[k]), 32'd1);
    end
    ready = 1'b1;
    idle(24);
    for (int k = 0; k < 2; k++) begin
      chk("t2_beats", k, 32'(bn[k]), 32'd16);
      for (int i = 0; i < 16; i++)
        chk("t2_pix", k, 32'({blog[k][i].d, blog[k][i].r, blog[k][i].c}), 32'({10'h150, 4'(i), 4'd0, 4'(i)}));
    end
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    for (int k = 0; k < 2; k++) chk("t2_ovf_clr", k, 32'(o_ovf[k]), 32'd0);

    // Encoding error mid-row, then clear (with and without a coinciding error)
    clear_logs();
    for (int i = 0; i < 8; i++) step(16'h0001, oh(i));
    step(16'h0001, 16'h0003);
    for (int k = 0; k < 2; k++) chk("t3_enc", k, 32'(o_enc[k]), 32'd1);
    for (int i = 8; i < 16; i++) step(16'h0001, oh(i));
    idle(5);
    err_clr = 1'b1;
    step(16'h0001, 16'h0003);
    for (int k = 0; k < 2; k++) chk("t3_enc_hold", k, 32'(o_enc[k]), 32'd1);
    idle(1);
    err_clr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("t3_enc_clr", k, 32'(o_enc[k]), 32'd0);
      chk("t3_beats", k, 32'(bn[k]), 32'd16);
      chk("t3_col8", k, 32'({blog[k][8].r, blog[k][8].c}), 32'h08);
    end

    // Skipped pixel (2,5)
    do_reset();
    clear_logs();
    run_frame(2 * 16 + 5);
    idle(8);
    for (int k = 0; k < 2; k++) begin
      chk("t4_beats", k, 32'(bn[k]), 32'd255);
      chk("t4_seq", k, 32'(o_seq[k]), 32'(ORDER));
      chk("t4_after_skip", k, 32'({blog[k][37].r, blog[k][37].c}), 32'h26);
      chk("t4_frame_done", k, 32'(fdn[k]), 32'd1);
    end

    // (0,0) arriving inside a frame
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    clear_logs();
    step(16'h0001, 16'h0001);
    step(16'h0001, 16'h0002);
    step(16'h0001, 16'h0001);
    step(16'h0001, 16'h0002);
    idle(6);
    for (int k = 0; k < 2; k++) begin
      chk("t4b_beats", k, 32'(bn[k]), 32'd4);
      chk("t4b_restart", k, 32'({blog[k][2].r, blog[k][2].c, blog[k][2].sof}), 32'h001);
      chk("t4b_seq", k, 32'(o_seq[k]), 32'(ORDER));
    end

    // Reset in the middle of a frame with pixels buffered
    do_reset();
    clear_logs();
    for (int i = 0; i < 40; i++) begin
      ready = (i < 32);
      step(oh(i / 16), oh(i % 16));
    end
    for (int k = 0; k < 2; k++) chk("t5_buffered", k, 32'(o_vld[k]), 32'd1);
    rst = 1'b1;
    step(oh(2), oh(8));
    for (int k = 0; k < 2; k++) chk("t5_rst_valid", k, 32'(o_vld[k]), 32'd0);
    idle(1);
    rst = 1'b0;
    clear_logs();
    ready = 1'b1;
    step(oh(2), oh(9));
    step(oh(2), oh(10));
    step(16'h0001, 16'h0001);
    step(16'h0001, 16'h0002);
    idle(6);
    for (int k = 0; k < 2; k++) begin
      chk("t5_beats", k, 32'(bn[k]), 32'd2);
      chk("t5_first", k, 32'({blog[k][0].d, blog[k][0].r, blog[k][0].c, blog[k][0].sof}), 32'({14'h1500, 9'h001}));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
